// File: rtl/coord_frame_latch_if.sv
// coord_frame_latch_if
//   Bundles the tracker-side inputs and the SPI-side outputs of the frame latch.
//   master : the source mux / SPI slave side (drives v_sync, cs and the muxed
//            tracker results, observes the latched values)
//   slave  : the frame latch itself
//   Inputs : v_sync (active low), cs (async, active low), x/y_coor_in[9:0],
//            red_detect_in, shoot_in, target_off_in
//   Outputs: x/y_coor_out[9:0], red_detect_out, shoot_out, target_off_out,
//            frame_cnt[CNT_W-1:0], update_pulse, overrun
interface coord_frame_latch_if #(
  parameter int CNT_W = 8
);
  logic             v_sync;
  logic             cs;
  logic [9:0]       x_coor_in;
  logic [9:0]       y_coor_in;
  logic             red_detect_in;
  logic             shoot_in;
  logic             target_off_in;
  logic [9:0]       x_coor_out;
  logic [9:0]       y_coor_out;
  logic             red_detect_out;
  logic             shoot_out;
  logic             target_off_out;
  logic [CNT_W-1:0] frame_cnt;
  logic             update_pulse;
  logic             overrun;

  modport master (
    output v_sync, cs, x_coor_in, y_coor_in, red_detect_in, shoot_in, target_off_in,
    input  x_coor_out, y_coor_out, red_detect_out, shoot_out, target_off_out,
           frame_cnt, update_pulse, overrun
  );

  modport slave (
    input  v_sync, cs, x_coor_in, y_coor_in, red_detect_in, shoot_in, target_off_in,
    output x_coor_out, y_coor_out, red_detect_out, shoot_out, target_off_out,
           frame_cnt, update_pulse, overrun
  );
endinterface

// File: rtl/coord_frame_latch.sv
// coord_frame_latch
//   Frame-synchronous staging register between the auto/manual source mux and
//   the SPI slave. Tracker results are sampled into a shadow frame at every
//   falling edge of v_sync (detect hysteresis + optional coordinate averaging),
//   and the shadow is copied to the outputs only while no SPI transaction is
//   in progress, so one MISO word never mixes two frames.
//   Ports:
//     clk    : system clock
//     reset  : synchronous, active high
//     bus    : coord_frame_latch_if.slave (see interface header)
//   Parameters:
//     DET_ON  : consecutive detect frames to assert red_detect_out (1..15)
//     DET_OFF : consecutive no-detect frames to deassert it (1..15)
//     SMOOTH  : 0 = coordinates pass through, 1 = average of old and new
//     CNT_W   : frame_cnt width
module coord_frame_latch #(
  parameter int DET_ON  = 2,
  parameter int DET_OFF = 4,
  parameter int SMOOTH  = 1,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  coord_frame_latch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HOLD, COMMIT} state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       det;
    logic       shoot;
    logic       toff;
  } frame_t;

  localparam logic [3:0] ON_MAX  = 4'(DET_ON);
  localparam logic [3:0] OFF_MAX = 4'(DET_OFF);

  // ---------------------------------------------------------------------------
  // Edge detection: v_sync is already in clk domain, cs is not.
  // ---------------------------------------------------------------------------
  logic v_sync_q;
  logic cs_m, cs_s, cs_s_q;
  logic tick, cs_fall, cs_rise;

  // The cs synchroniser resets to 0 so that a cs held low through reset does
  // not produce a fake falling edge afterwards; a fake rising edge in IDLE is
  // harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_sync_q <= 1'b0;
      cs_m     <= 1'b0;
      cs_s     <= 1'b0;
      cs_s_q   <= 1'b0;
    end else begin
      v_sync_q <= bus.v_sync;
      cs_m     <= bus.cs;
      cs_s     <= cs_m;
      cs_s_q   <= cs_s;
    end
  end

  assign tick    = v_sync_q & ~bus.v_sync;
  assign cs_fall = cs_s_q & ~cs_s;
  assign cs_rise = ~cs_s_q & cs_s;

  // ---------------------------------------------------------------------------
  // Shadow frame
  // ---------------------------------------------------------------------------
  frame_t           shadow;
  frame_t           outq;
  logic [3:0]       on_cnt, off_cnt;
  logic [3:0]       on_nxt, off_nxt;
  logic             shoot_acc;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [10:0]      x_sum, y_sum;
  logic [9:0]       x_nxt, y_nxt;
  logic             load;
  logic             shoot_vis;

  always_comb begin
    on_nxt  = (on_cnt  >= ON_MAX)  ? ON_MAX  : on_cnt  + 4'd1;
    off_nxt = (off_cnt >= OFF_MAX) ? OFF_MAX : off_cnt + 4'd1;
    x_sum   = {1'b0, shadow.x} + {1'b0, bus.x_coor_in};
    y_sum   = {1'b0, shadow.y} + {1'b0, bus.y_coor_in};
    // Averaging only makes sense against a coordinate from a tracked target;
    // while the filtered detect is low the new position is taken as-is.
    if (SMOOTH != 0 && shadow.det) begin
      x_nxt = x_sum[10:1];
      y_nxt = y_sum[10:1];
    end else begin
      x_nxt = bus.x_coor_in;
      y_nxt = bus.y_coor_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow      <= '0;
      on_cnt      <= '0;
      off_cnt     <= '0;
      shoot_acc   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (bus.shoot_in) shoot_acc <= 1'b1;
      // The master is about to read a set shoot flag: drop it from the shadow
      // so only shoots arriving after this point can re-arm it.
      if (cs_fall && shoot_vis) shadow.shoot <= 1'b0;
      if (tick) begin
        frame_cnt_q  <= frame_cnt_q + 1'b1;
        shoot_acc    <= 1'b0;
        shadow.shoot <= (shadow.shoot & ~(cs_fall & shoot_vis)) | shoot_acc | bus.shoot_in;
        shadow.toff  <= bus.target_off_in;
        if (bus.red_detect_in) begin
          on_cnt   <= on_nxt;
          off_cnt  <= '0;
          shadow.x <= x_nxt;
          shadow.y <= y_nxt;
          if (on_nxt == ON_MAX) shadow.det <= 1'b1;
        end else begin
          off_cnt  <= off_nxt;
          on_cnt   <= '0;
          if (off_nxt == OFF_MAX) shadow.det <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------------
  state_t state;
  logic   pending;
  logic   shoot_seen;
  logic   update_q;
  logic   overrun_q;

  // IDLE does not load in the cs_fall cycle, so the word the master clocks out
  // is exactly what was on the outputs when the transaction began.
  always_comb begin
    load = 1'b0;
    case (state)
      IDLE:    load = pending & ~cs_fall;
      COMMIT:  load = pending;
      default: load = 1'b0;
    endcase
    shoot_vis = load ? shadow.shoot : outq.shoot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      outq       <= '0;
      update_q   <= 1'b0;
      overrun_q  <= 1'b0;
      shoot_seen <= 1'b0;
    end else begin
      update_q <= load;
      if (load) outq <= shadow;

      // A tick coinciding with a load keeps pending so the newer shadow
      // follows on the next cycle.
      if (tick)      pending <= 1'b1;
      else if (load) pending <= 1'b0;

      // An unpublished frame being replaced while cs is low is lost to the master.
      if (tick && pending && (state == HOLD || cs_fall)) overrun_q <= 1'b1;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state      <= HOLD;
            shoot_seen <= shoot_vis;
          end
        end
        HOLD: begin
          if (cs_rise) begin
            state      <= COMMIT;
            shoot_seen <= 1'b0;
            // The master has read the shoot flag; retire it. A newer shoot
            // already sits in the shadow or accumulator and comes back on load.
            if (shoot_seen) outq.shoot <= 1'b0;
          end
        end
        COMMIT: begin
          if (cs_fall) begin
            state      <= HOLD;
            shoot_seen <= shoot_vis;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x_coor_out     = outq.x;
  assign bus.y_coor_out     = outq.y;
  assign bus.red_detect_out = outq.det;
  assign bus.shoot_out      = outq.shoot;
  assign bus.target_off_out = outq.toff;
  assign bus.frame_cnt      = frame_cnt_q;
  assign bus.update_pulse   = update_q;
  assign bus.overrun        = overrun_q;

endmodule

// File: tb/tb_coord_frame_latch.sv
module tb_coord_frame_latch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // bs: SMOOTH=1 instance (primary), bp: SMOOTH=0 instance fed the same stimulus
  coord_frame_latch_if #(.CNT_W(8)) bs();
  coord_frame_latch_if #(.CNT_W(8)) bp();

  assign bp.v_sync        = bs.v_sync;
  assign bp.cs            = bs.cs;
  assign bp.x_coor_in     = bs.x_coor_in;
  assign bp.y_coor_in     = bs.y_coor_in;
  assign bp.red_detect_in = bs.red_detect_in;
  assign bp.shoot_in      = bs.shoot_in;
  assign bp.target_off_in = bs.target_off_in;

  coord_frame_latch #(.DET_ON(2), .DET_OFF(4), .SMOOTH(1), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .bus(bs)
  );
  coord_frame_latch #(.DET_ON(2), .DET_OFF(4), .SMOOTH(0), .CNT_W(8)) u_dut_p (
    .clk(clk), .reset(reset), .bus(bp)
  );

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One v_sync falling edge; k=0 is the tick cycle, outputs expected at k=2.
  task automatic send_frame(input logic [9:0] x, input logic [9:0] y, input logic det,
                            input logic toff, output int pulses, output int first_at);
    @(posedge clk); #1;
    bs.x_coor_in = x; bs.y_coor_in = y; bs.red_detect_in = det;
    bs.target_off_in = toff; bs.v_sync = 1'b0;
    pulses = 0; first_at = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bs.update_pulse) begin
        pulses++;
        if (first_at < 0) first_at = k;
      end
      if (k == 2) bs.v_sync = 1'b1;
    end
  endtask

  task automatic shoot_pulse();
    @(posedge clk); #1 bs.shoot_in = 1'b1;
    @(posedge clk); #1 bs.shoot_in = 1'b0;
  endtask

  task automatic cs_rise_count(output int pulses);
    @(negedge clk); bs.cs = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bs.update_pulse) pulses++;
    end
  endtask

  task automatic test_reset();
    bs.v_sync = 1'b1; bs.cs = 1'b1; bs.x_coor_in = '0; bs.y_coor_in = '0;
    bs.red_detect_in = 1'b0; bs.shoot_in = 1'b0; bs.target_off_in = 1'b0;
    reset = 1'b1;
    idle_cycles(4);
    @(posedge clk); #1 reset = 1'b0;
    idle_cycles(4);
    checks++;
    if ({bs.x_coor_out, bs.y_coor_out, bs.red_detect_out, bs.shoot_out, bs.target_off_out} !== 23'd0) begin
      $display("FAIL reset_outputs got %h exp 0",
               {bs.x_coor_out, bs.y_coor_out, bs.red_detect_out, bs.shoot_out, bs.target_off_out});
      failures++;
    end
    checks++;
    if ({bs.frame_cnt, bs.update_pulse, bs.overrun} !== 10'd0) begin
      $display("FAIL reset_status got cnt=%0d up=%0d ov=%0d exp 0", bs.frame_cnt, bs.update_pulse, bs.overrun);
      failures++;
    end
  endtask

  task automatic test_detect_on();
    int p, f;
    send_frame(10'd100, 10'd50, 1'b1, 1'b0, p, f);
    checks++;
    if (bs.red_detect_out !== 1'b0) begin
      $display("FAIL det_after_1 got %0d exp 0", bs.red_detect_out); failures++;
    end
    checks++;
    if (p !== 1 || f !== 2) begin
      $display("FAIL latency_1 got pulses=%0d at=%0d exp pulses=1 at=2", p, f); failures++;
    end
    send_frame(10'd100, 10'd50, 1'b1, 1'b0, p, f);
    checks++;
    if (bs.red_detect_out !== 1'b1) begin
      $display("FAIL det_after_2 got %0d exp 1", bs.red_detect_out); failures++;
    end
    checks++;
    if (p !== 1 || f !== 2) begin
      $display("FAIL latency_2 got pulses=%0d at=%0d exp pulses=1 at=2", p, f); failures++;
    end
    send_frame(10'd100, 10'd50, 1'b1, 1'b0, p, f);
    checks++;
    if (bs.x_coor_out !== 10'd100 || bs.y_coor_out !== 10'd50) begin
      $display("FAIL xy_frame3 got x=%0d y=%0d exp x=100 y=50", bs.x_coor_out, bs.y_coor_out); failures++;
    end
    checks++;
    if (p !== 1 || f !== 2) begin
      $display("FAIL latency_3 got pulses=%0d at=%0d exp pulses=1 at=2", p, f); failures++;
    end
    checks++;
    if (bs.frame_cnt !== 8'd3) begin
      $display("FAIL frame_cnt got %0d exp 3", bs.frame_cnt); failures++;
    end
  endtask

  task automatic test_smoothing();
    int p, f;
    send_frame(10'd200, 10'd50, 1'b1, 1'b0, p, f);
    checks++;
    if (bs.x_coor_out !== 10'd150) begin
      $display("FAIL smooth_150 got %0d exp 150", bs.x_coor_out); failures++;
    end
    checks++;
    if (bp.x_coor_out !== 10'd200) begin
      $display("FAIL pass_200 got %0d exp 200", bp.x_coor_out); failures++;
    end
    send_frame(10'd200, 10'd50, 1'b1, 1'b0, p, f);
    checks++;
    if (bs.x_coor_out !== 10'd175) begin
      $display("FAIL smooth_175 got %0d exp 175", bs.x_coor_out); failures++;
    end
  endtask

  task automatic test_hysteresis();
    int p, f;
    for (int i = 0; i < 3; i++) begin
      send_frame(10'd999, 10'd999, 1'b0, (i == 1), p, f);
      checks++;
      if (bs.red_detect_out !== 1'b1 || bs.x_coor_out !== 10'd175) begin
        $display("FAIL off_frame%0d got det=%0d x=%0d exp det=1 x=175", i, bs.red_detect_out, bs.x_coor_out);
        failures++;
      end
      if (i == 1) begin
        checks++;
        if (bs.target_off_out !== 1'b1) begin
          $display("FAIL target_off got %0d exp 1", bs.target_off_out); failures++;
        end
      end
    end
    send_frame(10'd999, 10'd999, 1'b0, 1'b0, p, f);
    checks++;
    if (bs.red_detect_out !== 1'b0 || bs.target_off_out !== 1'b0) begin
      $display("FAIL off_frame3 got det=%0d toff=%0d exp 0 0", bs.red_detect_out, bs.target_off_out);
      failures++;
    end
    send_frame(10'd300, 10'd60, 1'b1, 1'b0, p, f);
    checks++;
    if (bs.x_coor_out !== 10'd300 || bs.y_coor_out !== 10'd60 || bs.red_detect_out !== 1'b0) begin
      $display("FAIL redetect got x=%0d y=%0d det=%0d exp 300 60 0", bs.x_coor_out, bs.y_coor_out, bs.red_detect_out);
      failures++;
    end
  endtask

  task automatic test_hold_overrun();
    int p, f;
    @(negedge clk); bs.cs = 1'b0;
    idle_cycles(4);
    send_frame(10'd10, 10'd5, 1'b1, 1'b0, p, f);
    checks++;
    if (p !== 0 || bp.x_coor_out !== 10'd300 || bs.overrun !== 1'b0) begin
      $display("FAIL hold_1 got pulses=%0d x=%0d ov=%0d exp 0 300 0", p, bp.x_coor_out, bs.overrun);
      failures++;
    end
    send_frame(10'd20, 10'd5, 1'b1, 1'b0, p, f);
    checks++;
    if (p !== 0 || bp.x_coor_out !== 10'd300) begin
      $display("FAIL hold_2 got pulses=%0d x=%0d exp 0 300", p, bp.x_coor_out); failures++;
    end
    checks++;
    if (bs.overrun !== 1'b1 || bp.overrun !== 1'b1) begin
      $display("FAIL overrun got %0d/%0d exp 1/1", bs.overrun, bp.overrun); failures++;
    end
    cs_rise_count(p);
    checks++;
    if (p !== 1 || bp.x_coor_out !== 10'd20) begin
      $display("FAIL commit got pulses=%0d x=%0d exp 1 20", p, bp.x_coor_out); failures++;
    end
    // smoothed instance: 10 loaded directly (detect was low), then (10+20)>>1
    checks++;
    if (bs.x_coor_out !== 10'd15 || bs.red_detect_out !== 1'b1) begin
      $display("FAIL commit_smooth got x=%0d det=%0d exp 15 1", bs.x_coor_out, bs.red_detect_out);
      failures++;
    end
    checks++;
    if (bs.overrun !== 1'b1) begin
      $display("FAIL overrun_sticky got %0d exp 1", bs.overrun); failures++;
    end
  endtask

  task automatic test_shoot();
    int p, f;
    idle_cycles(3);
    shoot_pulse();
    idle_cycles(3);
    checks++;
    if (bs.shoot_out !== 1'b0) begin
      $display("FAIL shoot_pre_tick got %0d exp 0", bs.shoot_out); failures++;
    end
    send_frame(10'd20, 10'd5, 1'b1, 1'b0, p, f);
    checks++;
    if (bs.shoot_out !== 1'b1) begin
      $display("FAIL shoot_latched got %0d exp 1", bs.shoot_out); failures++;
    end
    @(negedge clk); bs.cs = 1'b0;
    idle_cycles(4);
    shoot_pulse();
    idle_cycles(2);
    checks++;
    if (bs.shoot_out !== 1'b1) begin
      $display("FAIL shoot_frozen got %0d exp 1", bs.shoot_out); failures++;
    end
    cs_rise_count(p);
    checks++;
    if (bs.shoot_out !== 1'b0) begin
      $display("FAIL shoot_cleared got %0d exp 0", bs.shoot_out); failures++;
    end
    send_frame(10'd20, 10'd5, 1'b1, 1'b0, p, f);
    checks++;
    if (bs.shoot_out !== 1'b1) begin
      $display("FAIL shoot_survives got %0d exp 1", bs.shoot_out); failures++;
    end
  endtask

  task automatic test_reset_in_hold();
    int p, f;
    @(negedge clk); bs.cs = 1'b0;
    idle_cycles(4);
    send_frame(10'd77, 10'd7, 1'b1, 1'b1, p, f);
    @(posedge clk); #1 reset = 1'b1;
    idle_cycles(3);
    @(posedge clk); #1 reset = 1'b0;
    idle_cycles(2);
    checks++;
    if ({bs.x_coor_out, bs.y_coor_out, bs.red_detect_out, bs.shoot_out, bs.target_off_out} !== 23'd0) begin
      $display("FAIL hold_reset_out got %h exp 0",
               {bs.x_coor_out, bs.y_coor_out, bs.red_detect_out, bs.shoot_out, bs.target_off_out});
      failures++;
    end
    checks++;
    if (bs.overrun !== 1'b0 || bs.frame_cnt !== 8'd0) begin
      $display("FAIL hold_reset_stat got ov=%0d cnt=%0d exp 0 0", bs.overrun, bs.frame_cnt); failures++;
    end
    idle_cycles(3);
    send_frame(10'd40, 10'd8, 1'b1, 1'b0, p, f);
    checks++;
    if (p !== 1 || f !== 2 || bs.x_coor_out !== 10'd40 || bp.x_coor_out !== 10'd40) begin
      $display("FAIL post_reset_idle got pulses=%0d at=%0d x=%0d/%0d exp 1 2 40/40",
               p, f, bs.x_coor_out, bp.x_coor_out);
      failures++;
    end
    checks++;
    if (bs.frame_cnt !== 8'd1) begin
      $display("FAIL post_reset_cnt got %0d exp 1", bs.frame_cnt); failures++;
    end
    @(negedge clk); bs.cs = 1'b1;
    idle_cycles(4);
  endtask

  initial begin
    test_reset();
    idle_cycles(2);
    test_detect_on();
    test_smoothing();
    test_hysteresis();
    test_hold_overrun();
    test_shoot();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coord_frame_latch.md
Name: coord_frame_latch

Overview:
- Frame-synchronous staging register between the auto/manual source mux and the SPI slave.
- Samples the muxed tracker results (coordinates, detect, shoot, target_off) once per video frame and applies detect hysteresis plus optional coordinate smoothing.
- Keeps the values presented to the SPI slave frozen for the whole of any SPI transaction (cs low), so one MISO word never mixes two frames.
- Runs on sys_clk.

Parameters:
DET_ON, 2, consecutive frames with red_detect_in=1 needed to assert red_detect_out (1..15)
DET_OFF, 4, consecutive frames with red_detect_in=0 needed to deassert red_detect_out (1..15)
SMOOTH, 1, 0 = coordinates pass through; 1 = output is the average of the previous and new coordinate
CNT_W, 8, width of frame_cnt

Ports:
clk  input  1  pixel/system clock (sys_clk domain)
reset  input  1  synchronous, active-high reset
v_sync  input  1  VGA vertical sync, synchronous to clk, active low
cs  input  1  SPI chip select from external master, asynchronous, active low
x_coor_in  input  10  muxed aim x
y_coor_in  input  10  muxed aim y
red_detect_in  input  1  muxed target detected
shoot_in  input  1  muxed shoot request (level, may pulse mid-frame)
target_off_in  input  1  muxed target_off
x_coor_out  output  10  frame-latched x to SPI slave
y_coor_out  output  10  frame-latched y to SPI slave
red_detect_out  output  1  hysteresis-filtered detect
shoot_out  output  1  sticky shoot flag
target_off_out  output  1  frame-latched target_off
frame_cnt  output  CNT_W  frames sampled since reset, wraps
update_pulse  output  1  one-cycle strobe when outputs change to a new frame
overrun  output  1  sticky: at least one frame was overwritten while cs was low; cleared by reset only

Behaviour:
- One clock; reset is synchronous and active-high. All registers use clk and reset.
- Reset: every output is 0, shadow registers are 0, the hysteresis counters are 0, and the FSM is in IDLE.
- cs path: cs passes through a 2-FF synchroniser to give cs_s. cs_fall and cs_rise are detected on cs_s.
- Frame tick: tick=1 in cycle n when v_sync_q=1 and v_sync=0 (registered falling-edge detect).
- Shadow update happens at the clk edge ending cycle n.
- frame_cnt increments at every tick and wraps from 2^CNT_W-1 to 0.
- Detect hysteresis:
  - on_cnt counts consecutive frames with red_detect_in=1 and saturates at DET_ON; off_cnt counts consecutive frames with red_detect_in=0 and saturates at DET_OFF.
  - A frame with the opposite value clears the other counter.
  - shadow_det goes to 1 when on_cnt reaches DET_ON and to 0 when off_cnt reaches DET_OFF.
- Coordinates:
  - On a tick with red_detect_in=1: if SMOOTH=0, shadow = input. If SMOOTH=1, shadow = (shadow + input) >> 1, with an 11-bit sum and truncation.
  - First detect after shadow_det=0 loads the input directly, with no averaging.
  - On a tick with red_detect_in=0, the coordinates hold their last value.
- shoot: shoot_acc sets on any cycle with shoot_in=1. At a tick it is ORed into shadow_shoot and then cleared.
  - shoot_out clears only on cs_rise, and only if shoot_out was already 1 at the preceding cs_fall (the master has read it).
  - A shoot arriving during the transaction survives the clear.
- target_off: the shadow takes the input at each tick, with no filtering.
- FSM:
  - IDLE (cs_s=1): a shadow update sets pending; the cycle after pending, the outputs load from the shadow, update_pulse=1 and pending clears. Latency is tick cycle n → outputs valid in cycle n+2.
  - cs_fall → HOLD. The outputs are frozen. Ticks still update the shadow and set pending. A second tick while pending=1 inside HOLD sets overrun.
  - cs_rise → COMMIT (one cycle). If pending, load the outputs with update_pulse=1 and clear pending. Then go to IDLE.
- Simultaneous events:
  - A tick in the same cycle as cs_fall: the shadow still updates, but the outputs are not loaded until COMMIT.
  - A tick during COMMIT is treated as IDLE behaviour on the next cycle.
  - A reset asserted mid-HOLD returns to IDLE with all outputs 0, even if cs_s is still 0. The FSM then re-enters HOLD only on a new cs_fall.

Test Plan:
- Reset then 3 frames with red_detect_in=1, x=100, y=50, SMOOTH=1, cs high → red_detect_out=1 after the 2nd tick; x_coor_out=100, y_coor_out=50; update_pulse once per tick; outputs valid 2 cycles after each tick; frame_cnt=3.
- Detected at x=100, then frame with x=200 → x_coor_out=150; next frame x=200 → 175.
- red_detect_in drops for 3 frames → red_detect_out stays 1 and x holds 175; 4th zero frame → red_detect_out=0. Next detect at x=300 → x_coor_out=300, with no averaging.
- cs low across 2 ticks with x=10 then x=20 (SMOOTH=0) → outputs unchanged during cs low and overrun=1; 3 cycles after the cs rising edge (2 sync + COMMIT), x_coor_out=20 with a single update_pulse.
- 1-cycle shoot_in pulse mid-frame → shoot_out=1 after the tick. A cs transaction that starts after it then ends → shoot_out=0 after cs_rise. A shoot_in pulse during that transaction keeps shoot_out=1 after the next tick.
- Assert reset while cs low with pending=1 → all outputs 0, overrun=0, frame_cnt=0. After reset releases with cs still low, the next tick updates the outputs (IDLE).
